// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths,
// ALU select/op encodings and divider state encodings.
package ex_stage_pkg;

    localparam int AluSelBus  = 3;
    localparam int AluOpBus   = 8;
    localparam int RegDataBus = 32;
    localparam int RegAddrBus = 5;

    localparam logic RstEnable = 1'b0;

    localparam logic [AluSelBus-1:0] ALUSEL_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] ALUSEL_MOVE  = 3'b011;
    localparam logic [AluSelBus-1:0] ALUSEL_ARITH = 3'b100;

    localparam logic [AluOpBus-1:0] ALUOP_OR   = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] ALUOP_AND  = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] ALUOP_XOR  = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] ALUOP_NOR  = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] ALUOP_SLL  = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] ALUOP_SRL  = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] ALUOP_SRA  = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] ALUOP_ADD  = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] ALUOP_ADDU = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] ALUOP_SUB  = 8'b0010_0010;
    localparam logic [AluOpBus-1:0] ALUOP_SUBU = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] ALUOP_SLT  = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] ALUOP_SLTU = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] ALUOP_MFHI = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] ALUOP_MFLO = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] ALUOP_DIV  = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] ALUOP_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle,
// signs applied on the magnitudes' result in DONE.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic neg_q;
    logic neg_r;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] trial;
    logic fits;

    assign a_mag = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign b_mag = (signed_op && divisor[DATA_W-1]) ? -divisor : divisor;

    // rem can reach 2*divisor-1 after the shift, hence the extra bit
    assign rem_sh = {rem, quo[DATA_W-1]};
    assign trial  = rem_sh - {1'b0, dvs};
    assign fits   = rem_sh >= {1'b0, dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (annul) begin
            state <= DIV_IDLE;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quo   <= '0;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_DONE;
                        end else begin
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= signed_op &
                                     (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            neg_r <= signed_op & dividend[DATA_W-1];
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!start) begin
                        state <= DIV_IDLE;
                    end else begin
                        quo <= {quo[DATA_W-2:0], fits};
                        rem <= fits ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign ready     = (state == DIV_DONE);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, writeback muxing and the
// HI/LO path fed by the iterative divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = RegDataBus,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluSelBus-1:0]  ex_alusel,
    input  logic [AluOpBus-1:0]   ex_aluop,
    input  logic [DATA_W-1:0]     ex_reg1_data,
    input  logic [DATA_W-1:0]     ex_reg2_data,
    input  logic [RegAddrBus-1:0] ex_waddr,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic                  flush,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] dif;
    logic [DATA_W-1:0] res;
    logic [SH_W-1:0]   shamt;
    logic ov;
    logic slt;
    logic sltu;
    logic in_rst;

    logic sel_logic;
    logic sel_shift;
    logic sel_move;
    logic sel_arith;
    logic is_div;

    logic div_busy;
    logic div_ready;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;
    logic hilo_we;

    assign in_rst = (rst == RstEnable);
    assign a      = ex_reg1_data;
    assign b      = ex_reg2_data;
    assign shamt  = a[SH_W-1:0];
    assign sum    = a + b;
    assign dif    = a - b;
    assign slt    = $signed(a) < $signed(b);
    assign sltu   = a < b;

    assign sel_logic = (ex_alusel == ALUSEL_LOGIC);
    assign sel_shift = (ex_alusel == ALUSEL_SHIFT);
    assign sel_move  = (ex_alusel == ALUSEL_MOVE);
    assign sel_arith = (ex_alusel == ALUSEL_ARITH);
    assign is_div    = (ex_alusel == ALUSEL_NOP) &&
                       (ex_aluop == ALUOP_DIV || ex_aluop == ALUOP_DIVU);

    always_comb begin
        res = '0;
        ov  = 1'b0;
        unique case (1'b1)
            sel_logic: begin
                case (ex_aluop)
                    ALUOP_OR:  res = a | b;
                    ALUOP_AND: res = a & b;
                    ALUOP_XOR: res = a ^ b;
                    ALUOP_NOR: res = ~(a | b);
                    default:   res = '0;
                endcase
            end
            sel_shift: begin
                case (ex_aluop)
                    ALUOP_SLL: res = b << shamt;
                    ALUOP_SRL: res = b >> shamt;
                    ALUOP_SRA: res = $signed(b) >>> shamt;
                    default:   res = '0;
                endcase
            end
            sel_move: begin
                case (ex_aluop)
                    ALUOP_MFHI: res = hi_i;
                    ALUOP_MFLO: res = lo_i;
                    default:    res = '0;
                endcase
            end
            sel_arith: begin
                case (ex_aluop)
                    ALUOP_ADD: begin
                        res = sum;
                        ov  = (a[DATA_W-1] == b[DATA_W-1]) &&
                              (sum[DATA_W-1] != a[DATA_W-1]);
                    end
                    ALUOP_ADDU: res = sum;
                    ALUOP_SUB: begin
                        res = dif;
                        ov  = (a[DATA_W-1] != b[DATA_W-1]) &&
                              (dif[DATA_W-1] != a[DATA_W-1]);
                    end
                    ALUOP_SUBU: res = dif;
                    ALUOP_SLT:  res = {{(DATA_W-1){1'b0}}, slt};
                    ALUOP_SLTU: res = {{(DATA_W-1){1'b0}}, sltu};
                    default:    res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

    div_unit #(
        .DATA_W     (DATA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_op (ex_aluop == ALUOP_DIV),
        .annul     (flush),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .ready     (div_ready),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign hilo_we = !in_rst && is_div && div_ready && !flush;

    assign wd_o       = in_rst ? '0 : ex_waddr;
    assign wreg_o     = !in_rst && ex_wreg && !ov && !flush && !is_div;
    assign wdata_o    = in_rst ? '0 : res;
    assign whilo_o    = hilo_we;
    assign hi_o       = hilo_we ? div_r : '0;
    assign lo_o       = hilo_we ? div_q : '0;
    assign stallreq_o = !in_rst && is_div && !flush &&
                        (div_busy || !div_ready);

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its ex_* outputs.
- Produces the register-file writeback triple (waddr, wreg, wdata) for the EX/MEM register, plus HI/LO write requests.
- Single-cycle ALU for logic, shift, arithmetic and move ops.
- Iterative 32-cycle divider for DIV/DIVU. It raises a stall request so the upstream stages hold while it runs.

Parameters:
- DATA_W, 32, datapath width; fixed by the shared bus macros.
- DIV_CYCLES, 32, quotient bits resolved per division, one per cycle.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ex_alusel  input  3  operation class from ID/EX
- ex_aluop  input  8  operation subtype from ID/EX
- ex_reg1_data  input  32  operand 1; shift amount in [4:0]; dividend
- ex_reg2_data  input  32  operand 2; shifted value; divisor
- ex_waddr  input  5  destination register
- ex_wreg  input  1  destination write enable
- hi_i  input  32  current HI (already forwarded)
- lo_i  input  32  current LO (already forwarded)
- flush  input  1  annul the instruction in EX
- wd_o  output  5  writeback address
- wreg_o  output  1  writeback enable
- wdata_o  output  32  writeback data
- whilo_o  output  1  HI/LO write enable
- hi_o  output  32  HI write data
- lo_o  output  32  LO write data
- stallreq_o  output  1  hold IF/ID/ID-EX this cycle

Behaviour:
- Reset (rst low, asynchronous):
  - Divider FSM goes to IDLE; counter, partial remainder, divisor and quotient registers clear to 0.
  - While rst is low, all outputs are 0.
- Combinational path (same-cycle latency, alusel != NOP):
  - LOGIC: OR, AND, XOR, NOR.
  - SHIFT: SLL, SRL, SRA of reg2 by reg1[4:0].
  - ARITH: ADD, ADDU, SUB, SUBU are 32-bit modulo. SLT is a signed compare, SLTU unsigned; result is 0 or 1.
  - MOVE: MFHI returns hi_i, MFLO returns lo_i.
  - An unknown aluop within a valid class gives wdata_o = 0.
- Overflow: ADD or SUB with signed overflow forces wreg_o = 0; wdata_o is don't-care.
- Writeback passthrough: wd_o = ex_waddr and wreg_o = ex_wreg, except for the overflow case, flush, or a DIV op (DIV ops always give wreg_o = 0).
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE with aluop DIV/DIVU and no flush:
    - Divisor == 0: next state is DONE; the result is hi = lo = 0.
    - Otherwise: latch magnitudes (DIV takes absolute values of both operands, DIVU takes raw values), counter = 0, next state is BUSY.
  - BUSY: one restoring step per cycle. Shift {rem, quo} left by 1; if rem >= divisor, subtract it and set quo[0]. Counter increments. After step DIV_CYCLES-1, next state is DONE.
  - DONE: apply signs for DIV.
    - Quotient is negated when the operand signs differ.
    - Remainder takes the dividend's sign.
    - lo_o = quotient, hi_o = remainder, whilo_o = 1 for exactly this cycle. Next state is IDLE.
- stallreq_o = 1 whenever aluop is DIV/DIVU and the state is not DONE; otherwise 0.
- Timing, with the op first seen in cycle 0:
  - Nonzero divisor: stall in cycles 0..32, result in cycle 33.
  - Zero divisor: stall in cycle 0, result in cycle 1.
- ID/EX holds its contents under stall. The operands are latched only in IDLE, so later operand changes are ignored.
- flush: in any state, next state is IDLE. In the flush cycle, wreg_o = 0, whilo_o = 0 and stallreq_o = 0.
- An aluop that is not DIV/DIVU while in BUSY (protocol violation) aborts to IDLE with no HI/LO write.
- Back-to-back DIVs: DONE then IDLE costs one extra cycle before the second division starts.
- whilo_o is 0 for all non-DIV ops.

Decomposition:
- Shared defines package holds:
  - Bus widths: AluSelBus, AluOpBus, RegDataBus, RegAddrBus.
  - RstEnable, now defined as 1'b0.
  - alusel codes: NOP 000, LOGIC 001, SHIFT 010, MOVE 011, ARITH 100.
  - aluop codes (8-bit):
    - Logic: OR 00100101, AND 00100100, XOR 00100110, NOR 00100111.
    - Shift: SLL 01111100, SRL 00000010, SRA 00000011.
    - Add/sub: ADD 00100000, ADDU 00100001, SUB 00100010, SUBU 00100011.
    - Compare: SLT 00101010, SLTU 00101011.
    - Move: MFHI 00010000, MFLO 00010010.
    - Divide: DIV 00011010, DIVU 00011011, issued with alusel NOP.
  - Divider state encodings.
- Sub-module div_unit holds the FSM, counter and datapath.
  - Inputs: start, signed_op, dividend, divisor, annul.
  - Outputs: busy, ready, quotient, remainder.
  - ex_stage instantiates it and keeps the combinational ALU and muxing.

Test Plan:
- ARITH ADD, reg1 = 0x7FFFFFFF, reg2 = 1, wreg = 1, waddr = 5 -> wreg_o = 0 same cycle. ADDU with the same operands -> wreg_o = 1, wdata_o = 0x80000000, wd_o = 5.
- SRA, reg1 = 4, reg2 = 0xF0000000 -> wdata_o = 0xFF000000. SLT, reg1 = 0xFFFFFFFF, reg2 = 1 -> 1. SLTU with the same operands -> 0.
- DIV, reg1 = -7, reg2 = 2, held under stall -> stallreq_o = 1 in cycles 0..32. Cycle 33: whilo_o = 1, lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, stallreq_o = 0.
- DIVU, reg1 = 100, reg2 = 0 -> stall 1 cycle. Cycle 1: whilo_o = 1, hi_o = lo_o = 0.
- DIVU 100/7 with flush pulsed in cycle 10 -> FSM to IDLE, whilo_o never asserted, stallreq_o = 0 from cycle 10. A new DIVU 100/7 then yields lo_o = 14, hi_o = 2 after 33 cycles.
- rst dropped low mid-division (cycle 15), raised again with NOP inputs -> outputs 0 immediately, no whilo_o pulse, stallreq_o = 0.
